// File: rtl/test_chain_sequencer.sv
`timescale 1ns/1ps
// Sequences a chain of test units one at a time using level go/done handshakes,
// with per-unit timeout, skip masking, abort and a pass/timeout/skip summary.
module test_chain_sequencer #(
    parameter int NUM_UNITS      = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int UW            = $clog2(NUM_UNITS)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_UNITS-1:0] skip_mask,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] unit_go,
    output logic [UW-1:0]        cur_unit,
    output logic                 busy,
    output logic                 all_done,
    output logic                 aborted,
    output logic [NUM_UNITS-1:0] timeout_mask,
    output logic [NUM_UNITS-1:0] skipped_mask,
    output logic [UW:0]          pass_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [UW-1:0] LAST_UNIT  = UW'(NUM_UNITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [UW-1:0]        cur_unit_q, cur_unit_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_UNITS-1:0] unit_go_q, unit_go_d;
    logic [NUM_UNITS-1:0] timeout_mask_q, timeout_mask_d;
    logic [NUM_UNITS-1:0] skipped_mask_q, skipped_mask_d;
    logic [UW:0]          pass_count_q, pass_count_d;
    logic                 all_done_q, all_done_d;
    logic                 aborted_q, aborted_d;
    logic                 busy_q, busy_d;

    // One-hot decode of the current unit; avoids variable-indexed writes below.
    logic [NUM_UNITS-1:0] cur_sel;
    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_sel
            assign cur_sel[gi] = (cur_unit_q == UW'(gi));
        end
    endgenerate

    logic cur_skip;
    logic cur_done;
    assign cur_skip = |(skip_mask & cur_sel);
    assign cur_done = |(unit_done & cur_sel);

    always_comb begin
        state_d        = state_q;
        cur_unit_d     = cur_unit_q;
        timer_d        = timer_q;
        unit_go_d      = unit_go_q;
        timeout_mask_d = timeout_mask_q;
        skipped_mask_d = skipped_mask_q;
        pass_count_d   = pass_count_q;
        all_done_d     = all_done_q;
        aborted_d      = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    unit_go_d      = '0;
                    timeout_mask_d = '0;
                    skipped_mask_d = '0;
                    pass_count_d   = '0;
                    all_done_d     = 1'b0;
                    aborted_d      = 1'b0;
                    cur_unit_d     = '0;
                    state_d        = S_ARM;
                end
            end
            S_ARM: begin
                if (cur_skip) begin
                    skipped_mask_d = skipped_mask_q | cur_sel;
                    state_d        = S_ADVANCE;
                end else begin
                    unit_go_d = unit_go_q | cur_sel;
                    timer_d   = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // Done is checked first so it wins over a same-cycle timeout.
                if (cur_done) begin
                    pass_count_d = pass_count_q + (UW+1)'(1);
                    state_d      = S_ADVANCE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_mask_d = timeout_mask_q | cur_sel;
                    state_d        = S_ADVANCE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ADVANCE: begin
                if (cur_unit_q == LAST_UNIT) begin
                    state_d = S_FINISH;
                end else begin
                    cur_unit_d = cur_unit_q + UW'(1);
                    state_d    = S_ARM;
                end
            end
            S_FINISH: begin
                all_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards any in-flight update but keeps the results gathered so far.
        if (abort && (state_q != S_IDLE)) begin
            state_d        = S_IDLE;
            unit_go_d      = '0;
            aborted_d      = 1'b1;
            all_done_d     = 1'b0;
            timeout_mask_d = timeout_mask_q;
            skipped_mask_d = skipped_mask_q;
            pass_count_d   = pass_count_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cur_unit_q     <= '0;
            timer_q        <= '0;
            unit_go_q      <= '0;
            timeout_mask_q <= '0;
            skipped_mask_q <= '0;
            pass_count_q   <= '0;
            all_done_q     <= 1'b0;
            aborted_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_unit_q     <= cur_unit_d;
            timer_q        <= timer_d;
            unit_go_q      <= unit_go_d;
            timeout_mask_q <= timeout_mask_d;
            skipped_mask_q <= skipped_mask_d;
            pass_count_q   <= pass_count_d;
            all_done_q     <= all_done_d;
            aborted_q      <= aborted_d;
            busy_q         <= busy_d;
        end
    end

    assign unit_go      = unit_go_q;
    assign cur_unit     = cur_unit_q;
    assign busy         = busy_q;
    assign all_done     = all_done_q;
    assign aborted      = aborted_q;
    assign timeout_mask = timeout_mask_q;
    assign skipped_mask = skipped_mask_q;
    assign pass_count   = pass_count_q;

endmodule

// File: tb/tb_test_chain_sequencer.sv
`timescale 1ns/1ps
// Directed bench for test_chain_sequencer: table of whole-sequence scenarios
// driven by a per-unit responder model, plus hand-written latency/abort/reset cases.
module tb_test_chain_sequencer;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic         clock = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] skip_mask = '0;
    logic [N-1:0] unit_done = '0;
    logic [N-1:0] unit_go;
    logic [1:0]   cur_unit;
    logic         busy;
    logic         all_done;
    logic         aborted;
    logic [N-1:0] timeout_mask;
    logic [N-1:0] skipped_mask;
    logic [2:0]   pass_count;

    always #5 clock = ~clock;

    test_chain_sequencer #(
        .NUM_UNITS      (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .skip_mask    (skip_mask),
        .unit_done    (unit_done),
        .unit_go      (unit_go),
        .cur_unit     (cur_unit),
        .busy         (busy),
        .all_done     (all_done),
        .aborted      (aborted),
        .timeout_mask (timeout_mask),
        .skipped_mask (skipped_mask),
        .pass_count   (pass_count)
    );

    // Scenario record: stimulus (skip, per-unit done delay, forced-done) and expected summary.
    // A delay of 8'hFF means the unit never answers on its own.
    typedef struct {
        logic [3:0]      skip;
        logic [3:0][7:0] dly;
        logic [3:0]      frc;
        logic [3:0]      go;
        logic [3:0]      tmo;
        logic [3:0]      skp;
        int              pass;
        int              cycles;
    } vec_t;

    vec_t            tbl [8];
    logic [3:0][7:0] dly_cfg = {4{8'd5}};
    logic [3:0]      frc_cfg = '0;
    int              go_age [4] = '{0, 0, 0, 0};
    int              n_tests = 0;
    int              n_fail  = 0;
    int              cur_vec = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (case %0d): got %0h, expected %0h", nm, cur_vec, act, exp);
        end
    endtask

    // Advance one clock, then update the unit responders from the sampled go levels.
    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (unit_go[i]) go_age[i]++;
            else            go_age[i] = 0;
            unit_done[i] = frc_cfg[i] |
                           (unit_go[i] && (dly_cfg[i] != 8'hFF) && (go_age[i] >= int'(dly_cfg[i])));
        end
    endtask

    task automatic wait_all_done(input int lim, output int n);
        n = 0;
        while (!all_done && n < lim) begin
            tick();
            n++;
        end
        check("finish_within_bound", 32'(all_done), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        int n;
        cur_vec   = idx;
        dly_cfg   = tbl[idx].dly;
        frc_cfg   = tbl[idx].frc;
        skip_mask = tbl[idx].skip;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("cur_unit_after_start", 32'(cur_unit), 32'd0);
        check("go_cleared_on_start", 32'(unit_go), 32'd0);
        wait_all_done(400, n);
        check("cycles_to_all_done", 32'(n), 32'(tbl[idx].cycles));
        check("unit_go", 32'(unit_go), 32'(tbl[idx].go));
        check("pass_count", 32'(pass_count), 32'(tbl[idx].pass));
        check("timeout_mask", 32'(timeout_mask), 32'(tbl[idx].tmo));
        check("skipped_mask", 32'(skipped_mask), 32'(tbl[idx].skp));
        check("busy_at_end", 32'(busy), 32'd0);
        check("aborted_at_end", 32'(aborted), 32'd0);
        check("summary_total", 32'(int'(pass_count) + $countones(timeout_mask) + $countones(skipped_mask)), 32'(N));
        tick();
        check("all_done_held", 32'(all_done), 32'd1);
        $display("[TB] case %0d: %0d cycles, go=%b pass=%0d tmo=%b skp=%b",
                 idx, n, unit_go, pass_count, timeout_mask, skipped_mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{skip:4'b0000, dly:{8'd5, 8'd5, 8'd5, 8'd5},   frc:4'b0000,
                   go:4'b1111, tmo:4'b0000, skp:4'b0000, pass:4, cycles:29};
        tbl[1] = '{skip:4'b0000, dly:{8'd5, 8'hFF, 8'd5, 8'd5},  frc:4'b0000,
                   go:4'b1111, tmo:4'b0100, skp:4'b0000, pass:3, cycles:40};
        tbl[2] = '{skip:4'b1010, dly:{8'd5, 8'd5, 8'd5, 8'd5},   frc:4'b0000,
                   go:4'b0101, tmo:4'b0000, skp:4'b1010, pass:2, cycles:19};
        tbl[3] = '{skip:4'b1111, dly:{8'd5, 8'd5, 8'd5, 8'd5},   frc:4'b0000,
                   go:4'b0000, tmo:4'b0000, skp:4'b1111, pass:0, cycles:9};
        tbl[4] = '{skip:4'b0000, dly:{4{8'hFF}},                 frc:4'b0000,
                   go:4'b1111, tmo:4'b1111, skp:4'b0000, pass:0, cycles:73};
        tbl[5] = '{skip:4'b0000, dly:{4{8'd1}},                  frc:4'b0000,
                   go:4'b1111, tmo:4'b0000, skp:4'b0000, pass:4, cycles:13};
        // Unit 0 done lands on the last timer cycle; units 1 and 3 hold done before arm.
        tbl[6] = '{skip:4'b0000, dly:{8'hFF, 8'd5, 8'd1, 8'd16}, frc:4'b1010,
                   go:4'b1111, tmo:4'b0000, skp:4'b0000, pass:4, cycles:32};
        tbl[7] = '{skip:4'b0000, dly:{8'd1, 8'd1, 8'd1, 8'd17},  frc:4'b0000,
                   go:4'b1111, tmo:4'b0001, skp:4'b0000, pass:3, cycles:28};

        // Reset state
        cur_vec = 90;
        #12;
        check("rst_unit_go", 32'(unit_go), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_all_done", 32'(all_done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_pass_count", 32'(pass_count), 32'd0);
        check("rst_timeout_mask", 32'(timeout_mask), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) run_vec(v);

        // Done of unit i sampled at edge m -> go of unit i+1 after edge m+2
        cur_vec = 100;
        dly_cfg = {4{8'd5}}; frc_cfg = '0; skip_mask = '0;
        pulse_start();
        for (int i = 0; i < N - 1; i++) begin
            n = 0;
            while (!unit_done[i] && n < 100) begin
                tick();
                n++;
            end
            check("done_seen", 32'(unit_done[i]), 32'd1);
            tick();
            check("go_next_after_m", 32'(unit_go[i+1]), 32'd0);
            tick();
            check("go_next_after_m1", 32'(unit_go[i+1]), 32'd0);
            tick();
            check("go_next_after_m2", 32'(unit_go[i+1]), 32'd1);
        end
        wait_all_done(100, n);
        check("latency_pass_count", 32'(pass_count), 32'd4);
        $display("[TB] case 100: handoff latency sequence complete");

        // Timeout fires exactly TMO cycles after go rises
        cur_vec = 101;
        dly_cfg = {8'd5, 8'hFF, 8'd5, 8'd5};
        pulse_start();
        n = 0;
        while (!unit_go[2] && n < 100) begin
            tick();
            n++;
        end
        check("go2_seen", 32'(unit_go[2]), 32'd1);
        n = 0;
        while (!timeout_mask[2] && n < 100) begin
            tick();
            n++;
        end
        check("timeout_delay", 32'(n), 32'(TMO));
        wait_all_done(100, n);
        check("timeout_unit3_ran", 32'(unit_go[3]), 32'd1);
        $display("[TB] case 101: timeout after %0d cycles", TMO);

        // Abort, ignored start while busy, abort+start in idle, abort in idle
        cur_vec = 102;
        dly_cfg = {4{8'd5}};
        pulse_start();
        tick();
        pulse_start();
        check("start_busy_ignored_go", 32'(unit_go), 32'b0001);
        check("start_busy_ignored_busy", 32'(busy), 32'd1);
        n = 0;
        while (!(cur_unit == 2'd1 && unit_go[1]) && n < 100) begin
            tick();
            n++;
        end
        check("reached_unit1", 32'(unit_go[1]), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_unit_go", 32'(unit_go), 32'd0);
        check("abort_aborted", 32'(aborted), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_all_done", 32'(all_done), 32'd0);
        check("abort_pass_kept", 32'(pass_count), 32'd1);
        tick();
        check("aborted_held", 32'(aborted), 32'd1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("start_wins_busy", 32'(busy), 32'd1);
        check("start_wins_aborted", 32'(aborted), 32'd0);
        wait_all_done(100, n);
        check("restart_pass_count", 32'(pass_count), 32'd4);
        check("restart_go", 32'(unit_go), 32'b1111);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_all_done", 32'(all_done), 32'd1);
        check("idle_abort_aborted", 32'(aborted), 32'd0);
        $display("[TB] case 102: abort/restart sequence complete");

        // Asynchronous reset mid-WAIT
        cur_vec = 103;
        pulse_start();
        n = 0;
        while (!unit_go[1] && n < 100) begin
            tick();
            n++;
        end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_unit_go", 32'(unit_go), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_cur_unit", 32'(cur_unit), 32'd0);
        check("async_rst_pass_count", 32'(pass_count), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        $display("[TB] case 103: async reset applied mid-wait");
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/test_chain_sequencer.md
Name: test_chain_sequencer

Overview:
- Synthesizable sequencer that releases a chain of test units one at a time.
- Each unit gets a level "go" token and answers with a level "done", the same handshake as the simulation test-unit chain.
- Adds per-unit timeout, skip masking, abort, and a pass/timeout summary.
- Sits at the top of a test harness or BIST region; drives the first hop of each unit and collects results.

Parameters:
NUM_UNITS, 8, number of test units sequenced (2..32)
TIMEOUT_CYCLES, 1024, cycles allowed per unit after its go rises (>=2)
UW, $clog2(NUM_UNITS), width of the unit index (derived; do not override)

Ports:
clock  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle start request
abort  input  1  single-cycle abort request
skip_mask  input  NUM_UNITS  bit i=1: unit i is not run; sampled at each ARM
unit_done  input  NUM_UNITS  level done from each unit (its down-pass)
unit_go  output  NUM_UNITS  level go token to each unit (its up-pass); cumulative
cur_unit  output  UW  index of the unit being armed/waited
busy  output  1  sequence in progress
all_done  output  1  sequence completed; held until the next start
aborted  output  1  last sequence was aborted; held until the next start
timeout_mask  output  NUM_UNITS  bit i=1: unit i timed out
skipped_mask  output  NUM_UNITS  bit i=1: unit i was skipped
pass_count  output  UW+1  number of units that returned done

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0.
- States and transitions:
  - IDLE: start=1 -> clear unit_go, timeout_mask, skipped_mask, pass_count, all_done, aborted; cur_unit=0; go to ARM.
  - ARM (1 cycle), if skip_mask[cur_unit]=1: set skipped_mask[cur_unit]; go to ADVANCE.
  - ARM, otherwise: set unit_go[cur_unit]=1; clear the timer; go to WAIT.
  - WAIT, unit_done[cur_unit]=1: pass_count+1; go to ADVANCE.
  - WAIT, timer==TIMEOUT_CYCLES-1 with no done: set timeout_mask[cur_unit]; go to ADVANCE.
  - WAIT, otherwise: timer+1.
  - ADVANCE: cur_unit==NUM_UNITS-1 -> FINISH; else cur_unit+1 -> ARM.
  - FINISH (1 cycle): all_done=1; go to IDLE.
- busy=1 in ARM, WAIT, ADVANCE and FINISH; 0 in IDLE.
- All outputs are registered.
- Latency:
  - start sampled at edge k -> busy and ARM after k -> unit_go[0] high after edge k+1.
  - Done for unit i sampled at edge m -> unit_go[i+1] high after edge m+2.
  - A skipped unit costs 2 cycles; unit_go is never raised for it.
- unit_go is cumulative: once raised, a bit stays 1 until the next start, abort or reset. This matches the chain semantics, where downstream units may wait on upstream go levels.
- Only unit_done[cur_unit] is sampled, and only in WAIT.
  - Done bits of other units are ignored.
  - A done already high when WAIT is entered is accepted on the first WAIT cycle.
- Done and timeout in the same cycle: done wins (counts as pass; no timeout bit).
- Timer width is $clog2(TIMEOUT_CYCLES)+1. A timeout fires exactly TIMEOUT_CYCLES cycles after WAIT entry.
- start while busy=1: ignored.
- abort while busy=1:
  - Next state IDLE; unit_go cleared to 0; aborted=1; all_done stays 0.
  - timeout_mask, skipped_mask and pass_count keep their values.
- abort in IDLE: ignored.
- abort and start in the same IDLE cycle: start wins.
- Reset mid-sequence: immediate return to the reset values (all outputs 0).
- pass_count + popcount(timeout_mask) + popcount(skipped_mask) == NUM_UNITS when all_done=1.

Test Plan:
Use NUM_UNITS=4, TIMEOUT_CYCLES=16.
1. Full pass: start; each unit raises done 5 cycles after its go -> unit_go ends at 4'b1111, pass_count=4, all_done=1, timeout_mask=0; unit_go[i+1] rises exactly 2 cycles after the cycle unit_done[i] is sampled.
2. Timeout: unit 2 never responds -> timeout_mask=4'b0100 set 16 cycles after unit_go[2] rises; unit 3 still runs; pass_count=3, all_done=1.
3. Skip: skip_mask=4'b1010 -> unit_go[1] and unit_go[3] never rise; skipped_mask=4'b1010; pass_count=2.
4. Boundary collision: unit 0 done asserted on the exact cycle timer==15 -> pass, timeout_mask[0]=0. Unit 1 done already high at arm -> accepted on the first WAIT cycle. Done from an idle unit is ignored.
5. Abort and restart:
   - abort while waiting on unit 1 -> unit_go=0, aborted=1, busy=0, all_done=0.
   - start during busy is ignored.
   - A new start clears aborted and completes normally.
6. Reset: rst_n pulled low asynchronously mid-WAIT -> all outputs 0 without a clock edge; start after release runs a full sequence.
